// File: rtl/pipe_controller.sv
// Pipelined LEGv8 control unit: decodes in ID, carries the control word through
// ID/EX, EX/MEM and MEM/WB, and resolves RAW hazards by stalling, flushing and forwarding.
module pipe_controller #(
    parameter int REG_W      = 5,
    parameter int ZERO_REG   = 31,
    parameter bit FORWARDING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      instr_id,
    input  logic [REG_W-1:0] rn_id,
    input  logic [REG_W-1:0] rm_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             branch_taken_mem,
    output logic             id_reg2loc,
    output logic             ex_alu_src,
    output logic [3:0]       ex_alu_control,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_branch,
    output logic             mem_branch_zero,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_rd,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             illegal_id,
    output logic             stall
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    typedef struct packed {
        logic       alu_src;
        logic [3:0] alu_control;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_zero;
        logic       reg_write;
        logic       mem_to_reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic branch_zero;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    ex_ctrl_t id_ctrl;
    logic     id_reg2loc_c;
    logic     id_illegal_c;
    logic     uses_rn;
    logic     uses_rm;
    logic     uses_rd;

    always_comb begin
        id_ctrl      = '0;
        id_reg2loc_c = 1'b0;
        id_illegal_c = 1'b0;
        uses_rn      = 1'b0;
        uses_rm      = 1'b0;
        uses_rd      = 1'b0;
        casez (instr_id)
            OP_LDUR: begin
                id_ctrl.alu_src     = 1'b1;
                id_ctrl.mem_to_reg  = 1'b1;
                id_ctrl.reg_write   = 1'b1;
                id_ctrl.mem_read    = 1'b1;
                id_ctrl.alu_control = 4'b0010;
                uses_rn             = 1'b1;
            end
            OP_STUR: begin
                id_reg2loc_c        = 1'b1;
                id_ctrl.alu_src     = 1'b1;
                id_ctrl.mem_write   = 1'b1;
                id_ctrl.alu_control = 4'b0010;
                uses_rn             = 1'b1;
                uses_rd             = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                id_ctrl.reg_write = 1'b1;
                uses_rn           = 1'b1;
                uses_rm           = 1'b1;
                case (instr_id)
                    OP_SUB:  id_ctrl.alu_control = 4'b0110;
                    OP_AND:  id_ctrl.alu_control = 4'b0000;
                    OP_ORR:  id_ctrl.alu_control = 4'b0001;
                    default: id_ctrl.alu_control = 4'b0010;
                endcase
            end
            11'b10110100???, 11'b10110101???: begin
                // CBZ and CBNZ differ only in opcode bit 3 (bit 24 of the instruction)
                id_reg2loc_c        = 1'b1;
                id_ctrl.branch      = 1'b1;
                id_ctrl.branch_zero = ~instr_id[3];
                id_ctrl.alu_control = 4'b0111;
                uses_rd             = 1'b1;
            end
            default: begin
                id_illegal_c = 1'b1;
            end
        endcase
    end

    // Sources that name XZR can never depend on an older instruction
    logic src_rn;
    logic src_rm;
    logic src_rd;

    assign src_rn = uses_rn && (rn_id != ZR);
    assign src_rm = uses_rm && (rm_id != ZR);
    assign src_rd = uses_rd && (rd_id != ZR);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    ex_ctrl_t         ex_ctrl_q,   ex_ctrl_d;
    logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
    mem_ctrl_t        mem_ctrl_q,  mem_ctrl_d;
    logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic             wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_W-1:0] wb_rd_q,     wb_rd_d;

    logic flush;
    logic hazard;
    logic idex_bubble;
    logic ex_dest_valid;
    logic mem_dest_valid;
    logic hit_ex;

    assign flush       = branch_taken_mem;
    assign idex_bubble = flush || hazard;

    assign ex_dest_valid  = ex_ctrl_q.reg_write  && (ex_rd_q  != ZR);
    assign mem_dest_valid = mem_ctrl_q.reg_write && (mem_rd_q != ZR);

    assign hit_ex = (src_rn && (rn_id == ex_rd_q)) ||
                    (src_rm && (rm_id == ex_rd_q)) ||
                    (src_rd && (rd_id == ex_rd_q));

    always_comb begin
        ex_ctrl_d = id_ctrl;
        ex_rd_d   = rd_id;
        if (idex_bubble) begin
            ex_ctrl_d = '0;
            ex_rd_d   = '0;
        end

        mem_ctrl_d.mem_read    = ex_ctrl_q.mem_read;
        mem_ctrl_d.mem_write   = ex_ctrl_q.mem_write;
        mem_ctrl_d.branch      = ex_ctrl_q.branch;
        mem_ctrl_d.branch_zero = ex_ctrl_q.branch_zero;
        mem_ctrl_d.reg_write   = ex_ctrl_q.reg_write;
        mem_ctrl_d.mem_to_reg  = ex_ctrl_q.mem_to_reg;
        mem_rd_d               = ex_rd_q;
        if (flush) begin
            mem_ctrl_d = '0;
            mem_rd_d   = '0;
        end

        // The resolving branch itself is never squashed
        wb_reg_write_d  = mem_ctrl_q.reg_write;
        wb_mem_to_reg_d = mem_ctrl_q.mem_to_reg;
        wb_rd_d         = mem_rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl_q       <= '0;
            ex_rd_q         <= '0;
            mem_ctrl_q      <= '0;
            mem_rd_q        <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
        end else begin
            ex_ctrl_q       <= ex_ctrl_d;
            ex_rd_q         <= ex_rd_d;
            mem_ctrl_q      <= mem_ctrl_d;
            mem_rd_q        <= mem_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and forwarding
    // ------------------------------------------------------------------
    logic [1:0] fwd_sel [2];

    generate
        if (FORWARDING) begin : g_fwd
            logic [REG_W-1:0] ex_src_q [2];
            logic [REG_W-1:0] ex_src_d [2];
            logic             wb_dest_valid;

            assign wb_dest_valid = wb_reg_write_q && (wb_rd_q != ZR);

            // Only a load still in EX cannot be forwarded in time
            assign hazard = ex_ctrl_q.mem_read && ex_dest_valid && hit_ex;

            always_comb begin
                ex_src_d[0] = rn_id;
                ex_src_d[1] = id_reg2loc_c ? rd_id : rm_id;
                if (idex_bubble) begin
                    ex_src_d[0] = '0;
                    ex_src_d[1] = '0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ex_src_q[0] <= '0;
                    ex_src_q[1] <= '0;
                end else begin
                    ex_src_q[0] <= ex_src_d[0];
                    ex_src_q[1] <= ex_src_d[1];
                end
            end

            // EX/MEM is the younger producer, so it wins over MEM/WB
            for (genvar gi = 0; gi < 2; gi++) begin : g_sel
                assign fwd_sel[gi] =
                    (mem_dest_valid && (mem_rd_q == ex_src_q[gi])) ? 2'b10 :
                    (wb_dest_valid  && (wb_rd_q  == ex_src_q[gi])) ? 2'b01 :
                                                                     2'b00;
            end
        end else begin : g_nofwd
            logic hit_mem;

            assign hit_mem = (src_rn && (rn_id == mem_rd_q)) ||
                             (src_rm && (rm_id == mem_rd_q)) ||
                             (src_rd && (rd_id == mem_rd_q));

            // WB writes before ID reads, so only EX and MEM producers block
            assign hazard = (ex_dest_valid && hit_ex) || (mem_dest_valid && hit_mem);

            for (genvar gi = 0; gi < 2; gi++) begin : g_sel
                assign fwd_sel[gi] = 2'b00;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall         = hazard && !flush;
    assign pc_write_en   = !stall;
    assign ifid_write_en = !stall;
    assign ifid_flush    = flush;

    assign id_reg2loc      = id_reg2loc_c;
    assign illegal_id      = id_illegal_c;
    assign ex_alu_src      = ex_ctrl_q.alu_src;
    assign ex_alu_control  = ex_ctrl_q.alu_control;
    assign fwd_a           = fwd_sel[0];
    assign fwd_b           = fwd_sel[1];
    assign mem_read        = mem_ctrl_q.mem_read;
    assign mem_write       = mem_ctrl_q.mem_write;
    assign mem_branch      = mem_ctrl_q.branch;
    assign mem_branch_zero = mem_ctrl_q.branch_zero;
    assign wb_reg_write    = wb_reg_write_q;
    assign wb_mem_to_reg   = wb_mem_to_reg_q;
    assign wb_rd           = wb_rd_q;

endmodule
